// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK packet receiver.
//
// Holds the sample/packet geometry, the weak-decision threshold, the frame
// marker, the receiver state type and a magnitude helper for the correlator.
// There are no ports; the receiver files import this package.
// The frame marker and HUNT state only matter when SYNC_DETECT_EN is defined.

package bpsk_pkg;

    localparam int DATA_WIDTH     = 12;
    localparam int WAVELENGTH     = 64;
    localparam int PACKET_SIZE    = 16;
    localparam int WEAK_THRESHOLD = 256;

    localparam logic [PACKET_SIZE-1:0] SYNC_WORD = 16'hCAFE;

    localparam int PHASE_WIDTH = $clog2(WAVELENGTH);
    localparam int CNT_WIDTH   = $clog2(PACKET_SIZE);

    // One symbol sums WAVELENGTH full-scale samples, which needs PHASE_WIDTH
    // extra magnitude bits. One more bit of headroom keeps the sum safe.
    localparam int ACC_WIDTH = DATA_WIDTH + PHASE_WIDTH + 1;

    typedef enum logic {
        HUNT,
        RECEIVE
    } state_t;

    // The most negative accumulator value has no positive twin at ACC_WIDTH.
    // This helper widens the value by one bit before it negates, so the
    // magnitude is always exact.
    function automatic logic [ACC_WIDTH:0] acc_magnitude(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] wide;
        wide = {a[ACC_WIDTH-1], a};
        return wide[ACC_WIDTH] ? -wide : wide;
    endfunction

endpackage

// File: rtl/bpsk_symbol_correlator.sv
// Symbol correlator for the BPSK receiver.
//
// Tracks the carrier phase and integrates each symbol against a square
// reference. The first half-period is added and the second half-period is
// subtracted. At each symbol boundary it decides the bit from the sign.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   sample_valid one sample per cycle in which it is high
//   sample       signed carrier sample
//   bit_valid    one-cycle pulse, a decided bit is present
//   bit_out      decided bit (1 = carrier inverted)
//   bit_weak     |correlation| below WEAK_THRESHOLD for this bit

module bpsk_symbol_correlator
    import bpsk_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic                         bit_valid,
    output logic                         bit_out,
    output logic                         bit_weak
);

    localparam logic [PHASE_WIDTH-1:0] HALF_PHASE = PHASE_WIDTH'(WAVELENGTH / 2);
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(WAVELENGTH - 1);
    localparam logic [ACC_WIDTH:0]     WEAK_LIMIT = (ACC_WIDTH + 1)'(WEAK_THRESHOLD);

    logic        [PHASE_WIDTH-1:0] phase;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   sample_ext;
    logic        [ACC_WIDTH:0]     acc_mag;
    logic                          symbol_end;

    // The running sum includes the current sample. The decision at the
    // symbol boundary therefore sees the final sample of the symbol.
    always_comb begin
        sample_ext = {{(ACC_WIDTH - DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
        if (phase < HALF_PHASE) begin
            acc_next = acc + sample_ext;
        end else begin
            acc_next = acc - sample_ext;
        end
        acc_mag    = acc_magnitude(acc_next);
        symbol_end = (phase == LAST_PHASE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            acc       <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            bit_weak  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (sample_valid) begin
                if (symbol_end) begin
                    phase     <= '0;
                    acc       <= '0;
                    bit_valid <= 1'b1;
                    bit_out   <= acc_next[ACC_WIDTH-1];
                    bit_weak  <= (acc_mag < WEAK_LIMIT);
                end else begin
                    phase <= phase + 1'b1;
                    acc   <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/bpsk_packet_rx.sv
// BPSK packet receiver top level.
//
// Decides bits from carrier samples and assembles them into packets, with
// the first received bit placed in the MSB. Packets go out through a
// one-entry valid/ready output register. If a completed packet finds the
// register still occupied, the new packet is dropped and overrun is set.
// Overrun is sticky until reset.
//
// Optional build macro SYNC_DETECT_EN: the receiver hunts for SYNC_WORD
// before it takes each packet. A weak bit during a packet aborts back to
// the hunt. Without the macro, framing runs freely from the first symbol
// after reset.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   sample_valid sample strobe
//   sample       signed carrier sample
//   bit_valid    one-cycle pulse per decided bit
//   bit_out      decided bit
//   bit_weak     decided bit had low correlation magnitude
//   packet       assembled packet (stable while packet_valid)
//   packet_valid packet holds unconsumed data
//   packet_ready consumer accepts the packet when high with packet_valid
//   overrun      sticky, a completed packet was dropped

module bpsk_packet_rx
    import bpsk_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic                         bit_valid,
    output logic                         bit_out,
    output logic                         bit_weak,
    output logic [PACKET_SIZE-1:0]       packet,
    output logic                         packet_valid,
    input  logic                         packet_ready,
    output logic                         overrun
);

`ifdef SYNC_DETECT_EN
    localparam state_t ENTRY_STATE = HUNT;
`else
    localparam state_t ENTRY_STATE = RECEIVE;
`endif

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(PACKET_SIZE - 1);

    state_t                 state;
    state_t                 state_next;
    logic [PACKET_SIZE-1:0] shift_reg;
    logic [PACKET_SIZE-1:0] shifted;
    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic                   receiving;
    logic                   abort;
    logic                   sync_hit;
    logic                   packet_done;

    bpsk_symbol_correlator u_correlator (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .bit_valid    (bit_valid),
        .bit_out      (bit_out),
        .bit_weak     (bit_weak)
    );

    // The shift register value with the new bit included. In HUNT it serves
    // as the sync-search window. In RECEIVE it is the packet being built.
    assign shifted = {shift_reg[PACKET_SIZE-2:0], bit_out};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ENTRY_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
`ifdef SYNC_DETECT_EN
        case (state)
            HUNT:    if (sync_hit) state_next = RECEIVE;
            RECEIVE: if (abort || packet_done) state_next = HUNT;
            default: state_next = HUNT;
        endcase
`endif
    end

    // Per-bit qualifiers for the current state. A weak bit aborts the packet
    // before that bit can complete it.
    always_comb begin
        receiving = (state == RECEIVE);
`ifdef SYNC_DETECT_EN
        abort    = receiving && bit_valid && bit_weak;
        sync_hit = (state == HUNT) && bit_valid && (shifted == SYNC_WORD);
`else
        abort    = 1'b0;
        sync_hit = 1'b0;
`endif
        packet_done = receiving && bit_valid && !abort && (bit_cnt == LAST_BIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bit_valid) begin
            shift_reg <= shifted;
            if (sync_hit || abort || packet_done) begin
                bit_cnt <= '0;
            end else if (receiving) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // The output register accepts a new packet whenever it is empty or is
    // being drained in this same cycle. Otherwise the new packet is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            packet       <= '0;
            packet_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (packet_done) begin
            if (!packet_valid || packet_ready) begin
                packet       <= shifted;
                packet_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (packet_valid && packet_ready) begin
            packet_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpsk_packet_rx.sv
// Directed testbench for bpsk_packet_rx.
//
// Builds sine-carrier symbols (bit 1 = inverted carrier) and drives them
// one sample per clock. Packet contents, handshake behaviour, weak flags
// and reset handling are compared against hand-chosen values. Building
// with SYNC_DETECT_EN selects the sync-hunt sequence instead.

module tb_bpsk_packet_rx;
    import bpsk_pkg::*;

    logic                         clock;
    logic                         reset_n;
    logic                         sample_valid;
    logic signed [DATA_WIDTH-1:0] sample;
    logic                         bit_valid;
    logic                         bit_out;
    logic                         bit_weak;
    logic [PACKET_SIZE-1:0]       packet;
    logic                         packet_valid;
    logic                         packet_ready;
    logic                         overrun;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int bit_cnt_seen = 0;
    int weak_cnt_seen = 0;
    logic [PACKET_SIZE-1:0] last_xfer = '0;
    int snap_xfer;
    int snap_bits;
    int snap_weak;

    bpsk_packet_rx dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .bit_valid    (bit_valid),
        .bit_out      (bit_out),
        .bit_weak     (bit_weak),
        .packet       (packet),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Records handshake transfers and decided bits as they happen
    always @(posedge clock) begin
        if (reset_n && packet_valid && packet_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= packet;
        end
        if (reset_n && bit_valid) begin
            bit_cnt_seen <= bit_cnt_seen + 1;
            if (bit_weak) weak_cnt_seen <= weak_cnt_seen + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic signed [DATA_WIDTH-1:0] carrier(input logic b, input int amp, input int k);
        int v;
        v = $rtoi(amp * $sin(2.0 * 3.14159265358979 * k / WAVELENGTH));
        if (b) v = -v;
        return DATA_WIDTH'(v);
    endfunction

    // One symbol of carrier. With gap set, the strobe drops for a few
    // cycles mid-symbol while junk sits on the sample bus.
    task automatic send_symbol(input logic b, input int amp, input logic gap);
        for (int k = 0; k < WAVELENGTH; k++) begin
            if (gap && k == 20) begin
                sample_valid = 1'b0;
                sample = 12'sh7FF;
                repeat (3) tick();
            end
            sample_valid = 1'b1;
            sample = carrier(b, amp, k);
            tick();
        end
    endtask

    task automatic send_word(input logic [PACKET_SIZE-1:0] w, input int amp, input logic gap);
        for (int i = PACKET_SIZE - 1; i >= 0; i--) send_symbol(w[i], amp, gap);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        packet_ready = 1'b1;
        repeat (2) tick();
        check_output("reset_bit_valid", 32'(bit_valid), 32'd0);
        check_output("reset_bit_out", 32'(bit_out), 32'd0);
        check_output("reset_bit_weak", 32'(bit_weak), 32'd0);
        check_output("reset_packet", 32'(packet), 32'd0);
        check_output("reset_packet_valid", 32'(packet_valid), 32'd0);
        check_output("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();

`ifndef SYNC_DETECT_EN
        // CAFE with the consumer ready: check the two-cycle latency
        snap_weak = weak_cnt_seen;
        send_word(16'hCAFE, 1000, 1'b0);
        check_output("cafe_decide_pulse", 32'(bit_valid), 32'd1);
        check_output("cafe_not_yet_valid", 32'(packet_valid), 32'd0);
        tick();
        check_output("cafe_valid", 32'(packet_valid), 32'd1);
        check_output("cafe_packet", 32'(packet), 32'hCAFE);
        check_output("cafe_overrun", 32'(overrun), 32'd0);
        tick();
        check_output("cafe_drained", 32'(packet_valid), 32'd0);
        check_output("strong_not_weak", 32'(weak_cnt_seen - snap_weak), 32'd0);

        // Two packets with the consumer stalled: the second one is dropped
        packet_ready = 1'b0;
        send_word(16'h1234, 1000, 1'b0);
        tick();
        check_output("stall_first_valid", 32'(packet_valid), 32'd1);
        check_output("stall_first_packet", 32'(packet), 32'h1234);
        send_word(16'h5678, 1000, 1'b0);
        repeat (2) tick();
        check_output("stall_keeps_old", 32'(packet), 32'h1234);
        check_output("stall_still_valid", 32'(packet_valid), 32'd1);
        check_output("stall_overrun", 32'(overrun), 32'd1);
        pulse_reset();
        tick();
        check_output("overrun_cleared", 32'(overrun), 32'd0);
        check_output("valid_cleared", 32'(packet_valid), 32'd0);

        // The second packet lands in the same cycle the first one drains
        send_word(16'h1234, 1000, 1'b0);
        tick();
        send_word(16'h5678, 1000, 1'b0);
        packet_ready = 1'b1;
        tick();
        packet_ready = 1'b0;
        check_output("same_cycle_packet", 32'(packet), 32'h5678);
        check_output("same_cycle_valid", 32'(packet_valid), 32'd1);
        check_output("same_cycle_overrun", 32'(overrun), 32'd0);
        packet_ready = 1'b1;
        tick();

        // Tiny amplitude: every decision is flagged weak
        snap_bits = bit_cnt_seen;
        snap_weak = weak_cnt_seen;
        send_word(16'h00FF, 2, 1'b0);
        repeat (3) tick();
        check_output("weak_bits_seen", 32'(bit_cnt_seen - snap_bits), 32'd16);
        check_output("weak_all_flagged", 32'(weak_cnt_seen - snap_weak), 32'd16);

        // Reset in the middle of a symbol after 5 bits, then one full packet with strobe gaps
        send_symbol(1'b1, 1000, 1'b0);
        send_symbol(1'b0, 1000, 1'b0);
        send_symbol(1'b1, 1000, 1'b0);
        send_symbol(1'b1, 1000, 1'b0);
        send_symbol(1'b0, 1000, 1'b0);
        for (int k = 0; k < 20; k++) begin
            sample_valid = 1'b1;
            sample = carrier(1'b1, 1000, k);
            tick();
        end
        sample_valid = 1'b0;
        pulse_reset();
        tick();
        snap_xfer = xfer_cnt;
        send_word(16'hA5A5, 1000, 1'b1);
        tick();
        check_output("a5a5_packet", 32'(packet), 32'hA5A5);
        repeat (3) tick();
        check_output("a5a5_one_packet", 32'(xfer_cnt - snap_xfer), 32'd1);
        check_output("a5a5_last_xfer", 32'(last_xfer), 32'hA5A5);
        check_output("a5a5_overrun", 32'(overrun), 32'd0);
`else
        // Noise bits, the sync word, then the payload
        snap_xfer = xfer_cnt;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] noise;
            noise = 8'h3C;
            send_symbol(noise[i], 1000, 1'b0);
        end
        send_word(16'hCAFE, 1000, 1'b0);
        repeat (2) tick();
        check_output("sync_state_receive", 32'(dut.state), 32'(RECEIVE));
        check_output("sync_word_not_delivered", 32'(packet_valid), 32'd0);
        send_word(16'hBEEF, 1000, 1'b0);
        tick();
        check_output("beef_packet", 32'(packet), 32'hBEEF);
        check_output("beef_valid", 32'(packet_valid), 32'd1);
        check_output("beef_back_to_hunt", 32'(dut.state), 32'(HUNT));
        repeat (3) tick();
        check_output("beef_one_packet", 32'(xfer_cnt - snap_xfer), 32'd1);
        check_output("beef_last_xfer", 32'(last_xfer), 32'hBEEF);

        // A weak bit mid-packet aborts the packet without raising overrun
        send_word(16'hCAFE, 1000, 1'b0);
        tick();
        check_output("abort_in_receive", 32'(dut.state), 32'(RECEIVE));
        for (int i = 0; i < 4; i++) send_symbol(1'b1, 1000, 1'b0);
        send_symbol(1'b0, 2, 1'b0);
        sample_valid = 1'b0;
        repeat (2) tick();
        check_output("abort_to_hunt", 32'(dut.state), 32'(HUNT));
        check_output("abort_no_packet", 32'(packet_valid), 32'd0);
        check_output("abort_no_overrun", 32'(overrun), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
